tm_program_feeder: RTL and testbench
====================================

Name: tm_program_feeder

Overview:
Automatic driver for the TuringMachine user-entry interface. It holds a program buffer of symbols written by a host, then replays the program onto input_data/Next/Done with the same setup/pulse/gap timing a human or bench uses. It then auto-steps the machine with Next pulses until Compute_done or a step limit is reached. It sits between the board I/O (or a UART loader) and the TuringMachine instance.

Parameters:
SYM_W, 4, width of one program symbol (matches TuringMachine input_data).
DEPTH, 64, program buffer entries.
SETUP_CYC, 3, cycles input_data is stable before Next rises.
PULSE_CYC, 2, cycles Next/Done are held high.
GAP_CYC, 2, low cycles after each Next/Done pulse during load.
RUN_GAP_CYC, 5, low cycles after each run-phase Next pulse before compute_done is sampled.
MAX_STEPS, 1000, run-phase step limit.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low (0 = reset)
wr_en  input  1  buffer write strobe
wr_addr  input  $clog2(DEPTH)  buffer write address
wr_data  input  SYM_W  symbol to write
prog_len  input  $clog2(DEPTH)+1  number of symbols to send, sampled on start
start  input  1  single-cycle pulse that begins load
run_en  input  1  1 = auto-step after load; sampled on start
compute_done  input  1  from TuringMachine Compute_done
input_data  output  SYM_W  to TuringMachine input_data
Next  output  1  to TuringMachine Next
Done  output  1  to TuringMachine Done
busy  output  1  high in any state except IDLE/HALT
loading  output  1  high during the symbol/Done phase
halted  output  1  high in HALT
timeout  output  1  HALT reached via MAX_STEPS (sticky until next start)
step_count  output  16  run-phase Next pulses issued, saturating

Behaviour:
- Reset (async, reset=0): state IDLE; input_data, Next, Done, busy, loading, halted, timeout, step_count all 0; index and timers 0. Buffer contents are not cleared.
- Writes: accepted only when busy=0. An address >= DEPTH is ignored.
- start (only when busy=0, i.e. IDLE or HALT):
  - Latch len = min(prog_len, DEPTH) and run_en.
  - Clear timeout and step_count, set index=0.
  - Go to SETUP, or to DONE_PULSE if len=0. start while busy is ignored.
- SETUP: input_data=buf[index] from the first cycle; hold SETUP_CYC cycles, then go to PULSE.
- PULSE: Next=1 for PULSE_CYC cycles, input_data held. Then go to GAP.
- GAP: Next=0 for GAP_CYC cycles. At exit, index++. If index==len, go to DONE_PULSE, else SETUP.
- DONE_PULSE: Done=1, Next=0 for PULSE_CYC cycles. Then DONE_GAP for GAP_CYC cycles, then:
  - RUN_PULSE if run_en was latched;
  - otherwise HALT with timeout=0.
- RUN_PULSE: Next=1 for PULSE_CYC cycles; step_count increments once on entry. Then RUN_GAP.
- RUN_GAP: Next=0 for RUN_GAP_CYC cycles. On the last cycle, sample compute_done:
  - 1 → HALT;
  - else if step_count==MAX_STEPS → HALT with timeout=1;
  - else RUN_PULSE.
- compute_done is ignored outside RUN_GAP's final cycle.
- HALT: all strobes 0, halted=1; step_count and timeout held.
- loading=1 in SETUP, PULSE, GAP, DONE_PULSE, DONE_GAP.
- Outputs Next, Done and input_data are registered (glitch-free). Next and Done are never high simultaneously.
- Cycles per symbol = SETUP_CYC+PULSE_CYC+GAP_CYC (7 at default).
- Reset mid-operation aborts immediately to IDLE with the reset values above.

Decomposition:
- Package tm_feeder_pkg: state enum (IDLE, SETUP, PULSE, GAP, DONE_PULSE, DONE_GAP, RUN_PULSE, RUN_GAP, HALT) and the timing constants' default values.
- One sub-module, tm_prog_buf: DEPTH x SYM_W register array with one write port and one combinational read port.

Test Plan:
- Write buf[0..2]={3,1,0}, prog_len=3, run_en=0, start:
  - input_data sequence 3,1,0;
  - each Next high exactly 2 cycles, with 3 stable cycles before;
  - Done pulse 2 cycles after the last gap;
  - halted=1 at cycle 3*7+4=25, step_count=0.
- prog_len=0, start → no Next pulses; Done high 2 cycles; HALT.
- Program connected to a TuringMachine #(4,64) loaded with the 30-symbol bench program, run_en=1:
  - Compute_done rises after pulse 12;
  - halted with step_count=12, timeout=0.
- run_en=1, compute_done tied 0, MAX_STEPS=4 → exactly 4 run Next pulses, halted=1, timeout=1.
- Corrupt-write and start-while-busy checks:
  - wr_en during loading → buffer unchanged, verified on the next load;
  - start pulse during loading → ignored, sequence unaffected.
- Assert reset=0 mid-PULSE → Next/busy/loading go 0 asynchronously, before the next clock edge. After release, start replays the full program from index 0.

Source files
------------

// File: rtl/tm_feeder_pkg.sv
`default_nettype none
// ============================================================================
// tm_feeder_pkg : shared state encoding and default timing for the feeder
// Revision      : 1.0
// ============================================================================
package tm_feeder_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SETUP      = 4'd1,
        PULSE      = 4'd2,
        GAP        = 4'd3,
        DONE_PULSE = 4'd4,
        DONE_GAP   = 4'd5,
        RUN_PULSE  = 4'd6,
        RUN_GAP    = 4'd7,
        HALT       = 4'd8
    } state_t;

    localparam int DEF_SYM_W       = 4;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_SETUP_CYC   = 3;
    localparam int DEF_PULSE_CYC   = 2;
    localparam int DEF_GAP_CYC     = 2;
    localparam int DEF_RUN_GAP_CYC = 5;
    localparam int DEF_MAX_STEPS   = 1000;

    localparam int TIMER_W = 16;
    localparam int STEP_W  = 16;

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (v == {STEP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tm_prog_buf.sv
`default_nettype none
// ============================================================================
// tm_prog_buf : DEPTH x SYM_W program store, one write port, async read port
// Revision    : 1.0
// ============================================================================
module tm_prog_buf #(
    parameter int SYM_W = 4,
    parameter int DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [SYM_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [SYM_W-1:0]         rdata
);

    logic [SYM_W-1:0] mem [DEPTH];

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    always_ff @(posedge clock) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/tm_program_feeder.sv
`default_nettype none
// ============================================================================
// tm_program_feeder : replays a buffered program onto the TuringMachine entry
//                     strobes, then auto-steps it until Compute_done/limit
// Revision          : 1.0
// ============================================================================
module tm_program_feeder
    import tm_feeder_pkg::*;
#(
    parameter int SYM_W       = DEF_SYM_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int PULSE_CYC   = DEF_PULSE_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int RUN_GAP_CYC = DEF_RUN_GAP_CYC,
    parameter int MAX_STEPS   = DEF_MAX_STEPS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SYM_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     start,
    input  logic                     run_en,
    input  logic                     compute_done,
    output logic [SYM_W-1:0]         input_data,
    output logic                     Next,
    output logic                     Done,
    output logic                     busy,
    output logic                     loading,
    output logic                     halted,
    output logic                     timeout,
    output logic [STEP_W-1:0]        step_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [LW-1:0]      index, index_nxt;
    logic [LW-1:0]      len, len_nxt;
    logic               run_lat, run_nxt;
    logic               timeout_nxt;
    logic [STEP_W-1:0]  step_nxt;
    logic [SYM_W-1:0]   rd_data;

    tm_prog_buf #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clock (clock),
        .we    (wr_en && !busy),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (index_nxt[AW-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 1'b1;
        index_nxt   = index;
        len_nxt     = len;
        run_nxt     = run_lat;
        timeout_nxt = timeout;
        step_nxt    = step_count;
        case (state)
            IDLE, HALT: begin
                timer_nxt = '0;
                if (start) begin
                    len_nxt     = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
                    run_nxt     = run_en;
                    timeout_nxt = 1'b0;
                    step_nxt    = '0;
                    index_nxt   = '0;
                    state_nxt   = (len_nxt == '0) ? DONE_PULSE : SETUP;
                end
            end
            SETUP: begin
                if (timer == TIMER_W'(SETUP_CYC - 1)) begin
                    state_nxt = PULSE;
                    timer_nxt = '0;
                end
            end
            PULSE: begin
                if (timer == TIMER_W'(PULSE_CYC - 1)) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end
            end
            GAP: begin
                if (timer == TIMER_W'(GAP_CYC - 1)) begin
                    index_nxt = index + 1'b1;
                    timer_nxt = '0;
                    state_nxt = (index_nxt == len) ? DONE_PULSE : SETUP;
                end
            end
            DONE_PULSE: begin
                if (timer == TIMER_W'(PULSE_CYC - 1)) begin
                    state_nxt = DONE_GAP;
                    timer_nxt = '0;
                end
            end
            DONE_GAP: begin
                if (timer == TIMER_W'(GAP_CYC - 1)) begin
                    timer_nxt = '0;
                    if (run_lat) begin
                        state_nxt = RUN_PULSE;
                        step_nxt  = sat_inc(step_count);
                    end else begin
                        state_nxt = HALT;
                    end
                end
            end
            RUN_PULSE: begin
                if (timer == TIMER_W'(PULSE_CYC - 1)) begin
                    state_nxt = RUN_GAP;
                    timer_nxt = '0;
                end
            end
            RUN_GAP: begin
                // compute_done only matters once the machine has had the full gap to settle
                if (timer == TIMER_W'(RUN_GAP_CYC - 1)) begin
                    timer_nxt = '0;
                    if (compute_done) begin
                        state_nxt = HALT;
                    end else if (step_count == STEP_W'(MAX_STEPS)) begin
                        state_nxt   = HALT;
                        timeout_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN_PULSE;
                        step_nxt  = sat_inc(step_count);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with it glitch-free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            index      <= '0;
            len        <= '0;
            run_lat    <= 1'b0;
            timeout    <= 1'b0;
            step_count <= '0;
            input_data <= '0;
            Next       <= 1'b0;
            Done       <= 1'b0;
            busy       <= 1'b0;
            loading    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            index      <= index_nxt;
            len        <= len_nxt;
            run_lat    <= run_nxt;
            timeout    <= timeout_nxt;
            step_count <= step_nxt;
            if (state_nxt == SETUP) begin
                input_data <= rd_data;
            end
            Next    <= (state_nxt == PULSE) || (state_nxt == RUN_PULSE);
            Done    <= (state_nxt == DONE_PULSE);
            busy    <= (state_nxt != IDLE) && (state_nxt != HALT);
            loading <= (state_nxt == SETUP) || (state_nxt == PULSE) || (state_nxt == GAP) ||
                       (state_nxt == DONE_PULSE) || (state_nxt == DONE_GAP);
            halted  <= (state_nxt == HALT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tm_program_feeder.sv
`default_nettype none
// ============================================================================
// tb_tm_program_feeder : directed self-checking bench for tm_program_feeder
// Revision             : 1.0
// ============================================================================
module tb_tm_program_feeder;

    localparam int SYM_W = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LW    = 7;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [SYM_W-1:0] wr_data = '0;
    logic [LW-1:0]    prog_len = '0;
    logic             start = 1'b0;
    logic             start_b = 1'b0;
    logic             run_en = 1'b0;
    logic             compute_done = 1'b0;
    logic             compute_done_b = 1'b0;

    logic [SYM_W-1:0] input_data, input_data_b;
    logic             Next, Done, busy, loading, halted, timeout;
    logic             Next_b, Done_b, busy_b, loading_b, halted_b, timeout_b;
    logic [15:0]      step_count, step_count_b;

    int checks = 0;
    int failures = 0;
    logic [SYM_W-1:0] exp_prog [DEPTH];

    always #5 clock = ~clock;

    tm_program_feeder dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_len(prog_len), .start(start), .run_en(run_en), .compute_done(compute_done),
        .input_data(input_data), .Next(Next), .Done(Done), .busy(busy), .loading(loading),
        .halted(halted), .timeout(timeout), .step_count(step_count)
    );

    tm_program_feeder #(.MAX_STEPS(4)) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_len(prog_len), .start(start_b), .run_en(run_en), .compute_done(compute_done_b),
        .input_data(input_data_b), .Next(Next_b), .Done(Done_b), .busy(busy_b), .loading(loading_b),
        .halted(halted_b), .timeout(timeout_b), .step_count(step_count_b)
    );

    task automatic write_sym(input int a, input logic [SYM_W-1:0] d);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        exp_prog[a] = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int len, input logic run);
        @(negedge clock);
        prog_len = LW'(len); run_en = run; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic pulse_start_b(input int len, input logic run);
        @(negedge clock);
        prog_len = LW'(len); run_en = run; start_b = 1'b1;
        @(posedge clock);
        #1 start_b = 1'b0;
    endtask

    // Cycle k = 0 is the first cycle after the start edge; each symbol takes 3+2+2 cycles.
    task automatic check_load(input string name, input int len, input bit disturb);
        logic [4:0] ef;
        for (int k = 0; k < 7*len + 7; k++) begin
            @(negedge clock);
            if (k < 7*len)       ef = {((k % 7) == 3 || (k % 7) == 4), 4'b0110};
            else if (k < 7*len+2) ef = 5'b01110;
            else if (k < 7*len+4) ef = 5'b00110;
            else                  ef = 5'b00001;
            checks++;
            if ({Next, Done, loading, busy, halted} !== ef) begin
                failures++;
                $display("FAIL %s flags cycle %0d: got {Next,Done,loading,busy,halted}=%b want %b",
                         name, k, {Next, Done, loading, busy, halted}, ef);
            end
            if (k < 7*len) begin
                checks++;
                if (input_data !== exp_prog[k/7]) begin
                    failures++;
                    $display("FAIL %s input_data cycle %0d: got %h want %h", name, k, input_data, exp_prog[k/7]);
                end
            end
            if (disturb && k == 5) begin
                wr_en = 1'b1; wr_addr = AW'(1); wr_data = 4'hF; prog_len = LW'(1); start = 1'b1;
            end
            if (disturb && k == 6) begin
                wr_en = 1'b0; start = 1'b0;
            end
        end
        checks++;
        if (step_count !== 16'd0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s end: got step_count=%0d timeout=%b want 0/0", name, step_count, timeout);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if ({input_data, Next, Done, busy, loading, halted, timeout, step_count} !== '0) begin
            failures++;
            $display("FAIL reset_a: got data=%h N=%b D=%b busy=%b ld=%b h=%b to=%b sc=%0d want all 0",
                     input_data, Next, Done, busy, loading, halted, timeout, step_count);
        end
        checks++;
        if ({input_data_b, Next_b, Done_b, busy_b, loading_b, halted_b, timeout_b, step_count_b} !== '0) begin
            failures++;
            $display("FAIL reset_b: got nonzero outputs want all 0");
        end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        write_sym(0, 4'd3); write_sym(1, 4'd1); write_sym(2, 4'd0);
        pulse_start(3, 1'b0);
        check_load("basic", 3, 1'b0);
    endtask

    task automatic test_empty;
        pulse_start(0, 1'b0);
        check_load("empty", 0, 1'b0);
    endtask

    task automatic test_busy_write_start;
        write_sym(0, 4'h5); write_sym(1, 4'h9); write_sym(2, 4'hA); write_sym(3, 4'h6);
        pulse_start(4, 1'b0);
        check_load("busy_disturb", 4, 1'b1);
        pulse_start(4, 1'b0);
        check_load("busy_reload", 4, 1'b0);
    endtask

    task automatic test_reset_mid_pulse;
        pulse_start(4, 1'b0);
        repeat (4) @(negedge clock);
        checks++;
        if (Next !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre Next: got %b want 1", Next);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({Next, Done, busy, loading, halted, input_data} !== '0) begin
            failures++;
            $display("FAIL rst_async: got N=%b D=%b busy=%b ld=%b h=%b data=%h want all 0",
                     Next, Done, busy, loading, halted, input_data);
        end
        @(negedge clock);
        reset = 1'b1;
        pulse_start(4, 1'b0);
        check_load("replay", 4, 1'b0);
    endtask

    task automatic test_run_tm;
        int  load_p, run_p, cyc;
        logic prev;
        for (int i = 0; i < 30; i++) write_sym(i, SYM_W'((i * 7 + 3) % 16));
        pulse_start(30, 1'b1);
        load_p = 0; run_p = 0; cyc = 0; prev = 1'b0;
        while (!halted && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            if (Next && !prev) begin
                if (loading) begin
                    checks++;
                    if (load_p < 30 && input_data !== exp_prog[load_p]) begin
                        failures++;
                        $display("FAIL run_tm symbol %0d: got %h want %h", load_p, input_data, exp_prog[load_p]);
                    end
                    load_p++;
                end else begin
                    run_p++;
                    if (run_p == 12) compute_done = 1'b1;
                end
            end
            prev = Next;
        end
        checks++;
        if (halted !== 1'b1 || load_p != 30 || run_p != 12) begin
            failures++;
            $display("FAIL run_tm pulses: got halted=%b load=%0d run=%0d want 1/30/12", halted, load_p, run_p);
        end
        checks++;
        if (step_count !== 16'd12 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL run_tm status: got step_count=%0d timeout=%b want 12/0", step_count, timeout);
        end
        compute_done = 1'b0;
    endtask

    task automatic test_timeout;
        int  run_p, cyc;
        logic prev;
        pulse_start_b(1, 1'b1);
        run_p = 0; cyc = 0; prev = 1'b0;
        while (!halted_b && cyc < 500) begin
            @(negedge clock);
            cyc++;
            if (Next_b && !prev && !loading_b) run_p++;
            prev = Next_b;
        end
        checks++;
        if (halted_b !== 1'b1 || run_p != 4) begin
            failures++;
            $display("FAIL timeout pulses: got halted=%b run=%0d want 1/4", halted_b, run_p);
        end
        checks++;
        if (timeout_b !== 1'b1 || step_count_b !== 16'd4) begin
            failures++;
            $display("FAIL timeout status: got timeout=%b step_count=%0d want 1/4", timeout_b, step_count_b);
        end
        pulse_start_b(0, 1'b0);
        @(negedge clock);
        checks++;
        if (timeout_b !== 1'b0 || step_count_b !== 16'd0 || Done_b !== 1'b1) begin
            failures++;
            $display("FAIL timeout_clear: got timeout=%b step_count=%0d Done=%b want 0/0/1",
                     timeout_b, step_count_b, Done_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_busy_write_start();
        test_reset_mid_pulse();
        test_run_tm();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
